// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_pkg: shared state encoding and width limit for the bit-serial adder controller
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_e;
    localparam int SA_MAX_WIDTH = 64;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand request and result handshakes between requester and controller
// SERIAL_ADD_OVF_EN adds the signed-overflow flag to the result side.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
`ifdef SERIAL_ADD_OVF_EN
        , ovf
`endif
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
`ifdef SERIAL_ADD_OVF_EN
        , ovf
`endif
    );
endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// full_adder: combinational single-bit adder slice shared by the serial controller
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands one bit per clock, LSB first, through one full_adder
// SERIAL_ADD_OVF_EN adds a registered signed-overflow flag.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic clk,
    input logic rst,
    serial_adder_ctrl_if.slave bus
);
    sa_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic             fa_sum;
    logic             fa_carry;
    logic             last;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .carry(fa_carry)
    );

    // Shift form rather than a concatenation so WIDTH=1 needs no empty slice
    assign sum_next = (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    assign last     = cnt == CNT_W'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            a_sh          <= '0;
            b_sh          <= '0;
            sum_sh        <= '0;
            carry         <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            bus.ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.in_valid && bus.in_ready) begin
                    state        <= RUN;
                    a_sh         <= bus.a;
                    b_sh         <= bus.b;
                    carry        <= bus.cin;
                    cnt          <= '0;
                    sum_sh       <= '0;
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b1;
                end
                RUN: begin
                    sum_sh <= sum_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_carry;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.sum       <= sum_next;
                        bus.cout      <= fa_carry;
`ifdef SERIAL_ADD_OVF_EN
                        // carry still holds the carry into the MSB on this edge
                        bus.ovf       <= carry ^ fa_carry;
`endif
                    end
                end
                DONE: if (bus.out_ready) begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1
// Define SERIAL_ADD_OVF_EN to also check the overflow flag.
module tb_serial_adder_ctrl;
    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    res_t q[$];

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    function automatic res_t model(logic [7:0] a, logic [7:0] b, logic cin);
        res_t       r;
        logic [8:0] t;
        t      = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        r.sum  = t[7:0];
        r.cout = t[8];
        r.ovf  = (a[7] == b[7]) && (t[7] != a[7]);
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(logic [7:0] a, logic [7:0] b, logic cin);
        check("in_ready_idle", 64'(bus8.in_ready), 1);
        bus8.a        = a;
        bus8.b        = b;
        bus8.cin      = cin;
        bus8.in_valid = 1'b1;
        q.push_back(model(a, b, cin));
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        check("busy_run", 64'(bus8.busy), 1);
        check("in_ready_run", 64'(bus8.in_ready), 0);
    endtask

    task automatic wait_done(logic poke);
        int lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            bus8.in_valid = poke;
            bus8.a        = 8'h5A;
            bus8.b        = 8'h5A;
            if (poke) check("in_ready_poke", 64'(bus8.in_ready), 0);
            @(posedge clk); #1;
            lat++;
        end
        bus8.in_valid = 1'b0;
        check("latency", 64'(lat), 8);
    endtask

    task automatic take();
        res_t e;
        check("sb_size", 64'(q.size()), 1);
        e = q.pop_front();
        check("sum", 64'(bus8.sum), 64'(e.sum));
        check("cout", 64'(bus8.cout), 64'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", 64'(bus8.ovf), 64'(e.ovf));
`endif
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        check("out_valid_after", 64'(bus8.out_valid), 0);
        check("in_ready_after", 64'(bus8.in_ready), 1);
        check("busy_after", 64'(bus8.busy), 0);
        check("sum_hold_idle", 64'(bus8.sum), 64'(e.sum));
    endtask

    task automatic run8(logic [7:0] a, logic [7:0] b, logic cin);
        accept(a, b, cin);
        wait_done(1'b0);
        take();
    endtask

    initial begin
        bit seen;
        int lat;
        bus8.in_valid = 0; bus8.a = 0; bus8.b = 0; bus8.cin = 0; bus8.out_ready = 0;
        bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.cin = 0; bus1.out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 64'(bus8.in_ready), 1);
        check("rst_out_valid", 64'(bus8.out_valid), 0);
        check("rst_sum", 64'(bus8.sum), 0);
        check("rst_cout", 64'(bus8.cout), 0);
        check("rst_busy", 64'(bus8.busy), 0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", 64'(bus8.ovf), 0);
`endif
        run8(8'h0F, 8'h01, 1'b0);
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'hFF, 8'hFF, 1'b1);
        run8(8'h3C, 8'hA7, 1'b1);
        // operand pulses during RUN and DONE must be ignored
        accept(8'h12, 8'h34, 1'b0);
        wait_done(1'b1);
        for (int i = 0; i < 5; i++) begin
            bus8.in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_out_valid", 64'(bus8.out_valid), 1);
            check("bp_sum", 64'(bus8.sum), 64'(q[0].sum));
            check("bp_cout", 64'(bus8.cout), 64'(q[0].cout));
            check("bp_in_ready", 64'(bus8.in_ready), 0);
        end
        bus8.in_valid = 1'b0;
        take();
        // abort at cnt=3
        accept(8'hAA, 8'h55, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        check("abort_in_ready", 64'(bus8.in_ready), 1);
        check("abort_busy", 64'(bus8.busy), 0);
        seen = bus8.out_valid;
        repeat (12) begin @(posedge clk); #1; seen |= bus8.out_valid; end
        check("abort_no_out_valid", 64'(seen), 0);
        run8(8'h01, 8'h01, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
        run8(8'h7F, 8'h01, 1'b0);
        run8(8'h80, 8'h80, 1'b0);
        run8(8'h10, 8'h20, 1'b0);
`endif
        // WIDTH=1 instance
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1; bus1.in_valid = 1'b1;
        check("w1_in_ready", 64'(bus1.in_ready), 1);
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        check("w1_latency", 64'(lat), 1);
        check("w1_sum", 64'(bus1.sum), 1);
        check("w1_cout", 64'(bus1.cout), 1);
`ifdef SERIAL_ADD_OVF_EN
        check("w1_ovf", 64'(bus1.ovf), 0);
`endif
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        check("w1_out_valid_after", 64'(bus1.out_valid), 0);
        check("w1_in_ready_after", 64'(bus1.in_ready), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
